// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with a valid/ready handshake,
// stall (backpressure), synchronous flush and an optional 2-entry skid buffer.
//
// Parameters:
//   WIDTH     - payload width in bits
//   SKID      - 0: single register, combinational ready_o
//               1: two-entry skid buffer, ready_o decoded from registered state
//   RESET_VAL - value presented on data_o after reset
//
// Ports:
//   clk_i       - clock, rising edge
//   rst_i       - synchronous active-high reset (takes priority over flush_i)
//   valid_i     - upstream payload valid
//   ready_o     - this stage can accept a payload
//   data_i      - upstream payload
//   flush_i     - squash every held entry; a same-edge input is discarded
//   valid_o     - data_o holds a valid payload
//   ready_i     - downstream accepts (0 = stall)
//   data_o      - payload to downstream
//   occupancy_o - number of held entries (0..2)
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occupancy_o
);

  if (SKID != 0) begin : g_skid

    // Encoding matches the entry count so occupancy_o is the state itself.
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             ready, valid;
    logic             in_xfer, out_xfer;
    logic             load_main_in, load_main_skid, load_skid;

    // State register and datapath.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= EMPTY;
        main_q  <= RESET_VAL;
        skid_q  <= RESET_VAL;
      end else begin
        state_q <= state_d;
        if (load_main_in) begin
          main_q <= data_i;
        end else if (load_main_skid) begin
          main_q <= skid_q;
        end
        if (load_skid) begin
          skid_q <= data_i;
        end
      end
    end

    // Next-state logic. Flush empties the buffer and suppresses every load,
    // which discards a same-edge input; a same-edge output is simply consumed.
    always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush_i) begin
        state_d = EMPTY;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              load_main_in = 1'b1;
              state_d      = ONE;
            end
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              load_main_in = 1'b1;
            end else if (in_xfer) begin
              load_skid = 1'b1;
              state_d   = FULL;
            end else if (out_xfer) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (out_xfer) begin
              load_main_skid = 1'b1;
              state_d        = ONE;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    // Outputs depend only on registered state, so ready_o never sees ready_i.
    always_comb begin
      ready    = (state_q != FULL);
      valid    = (state_q != EMPTY);
      in_xfer  = valid_i && ready;
      out_xfer = valid && ready_i;
    end

    assign ready_o     = ready;
    assign valid_o     = valid;
    assign data_o      = main_q;
    assign occupancy_o = state_q;

  end else begin : g_flop

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             ready;

    assign ready = !valid_q || ready_i;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        data_q  <= RESET_VAL;
      end else if (flush_i) begin
        valid_q <= 1'b0;
      end else if (ready) begin
        valid_q <= valid_i;
        if (valid_i) begin
          data_q <= data_i;
        end
      end
    end

    assign ready_o     = ready;
    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign occupancy_o = {1'b0, valid_q};

  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench driving one skid-buffer instance and one
// single-register instance from a shared clock and reset.
module tb_pipe_stage_reg;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] F_RST = 32'hCAFE_F00D;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Skid-buffer instance signals.
  logic         s_valid_i = 1'b0, s_ready_i = 1'b0, s_flush = 1'b0;
  logic [W-1:0] s_data_i = '0;
  logic         s_ready_o, s_valid_o;
  logic [W-1:0] s_data_o;
  logic [1:0]   s_occ;

  // Single-register instance signals.
  logic         f_valid_i = 1'b0, f_ready_i = 1'b0, f_flush = 1'b0;
  logic [W-1:0] f_data_i = '0;
  logic         f_ready_o, f_valid_o;
  logic [W-1:0] f_data_o;
  logic [1:0]   f_occ;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .RESET_VAL('0)) u_skid (
    .clk_i(clk), .rst_i(rst), .valid_i(s_valid_i), .ready_o(s_ready_o),
    .data_i(s_data_i), .flush_i(s_flush), .valid_o(s_valid_o),
    .ready_i(s_ready_i), .data_o(s_data_o), .occupancy_o(s_occ)
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(0), .RESET_VAL(F_RST)) u_flop (
    .clk_i(clk), .rst_i(rst), .valid_i(f_valid_i), .ready_o(f_ready_o),
    .data_i(f_data_i), .flush_i(f_flush), .valid_o(f_valid_o),
    .ready_i(f_ready_i), .data_o(f_data_o), .occupancy_o(f_occ)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset with active inputs ----------------
    rst = 1'b1;
    s_valid_i = 1'b1; s_data_i = 32'hDEAD; s_ready_i = 1'b1;
    f_valid_i = 1'b1; f_data_i = 32'hDEAD; f_ready_i = 1'b1;
    tick(); tick();
    check("rst_s_valid", W'(s_valid_o), W'(0));
    check("rst_s_data",  s_data_o, 32'h0);
    check("rst_s_occ",   W'(s_occ), W'(0));
    check("rst_f_valid", W'(f_valid_o), W'(0));
    check("rst_f_data",  f_data_o, F_RST);
    check("rst_f_occ",   W'(f_occ), W'(0));
    rst = 1'b0;
    s_valid_i = 1'b0; f_valid_i = 1'b0;
    #1;
    check("rst_s_ready", W'(s_ready_o), W'(1));
    check("rst_f_ready", W'(f_ready_o), W'(1));

    // ---------------- streaming, both modes ----------------
    s_ready_i = 1'b1; f_ready_i = 1'b1;
    s_valid_i = 1'b1; s_data_i = 32'h11; f_valid_i = 1'b1; f_data_i = 32'h11;
    tick();
    check("str_s_d0", s_data_o, 32'h11); check("str_s_v0", W'(s_valid_o), W'(1));
    check("str_f_d0", f_data_o, 32'h11); check("str_f_v0", W'(f_valid_o), W'(1));
    s_data_i = 32'h22; f_data_i = 32'h22;
    tick();
    check("str_s_d1", s_data_o, 32'h22); check("str_s_v1", W'(s_valid_o), W'(1));
    check("str_f_d1", f_data_o, 32'h22); check("str_f_v1", W'(f_valid_o), W'(1));
    s_data_i = 32'h33; f_data_i = 32'h33;
    tick();
    check("str_s_d2", s_data_o, 32'h33); check("str_s_occ2", W'(s_occ), W'(1));
    check("str_f_d2", f_data_o, 32'h33); check("str_f_occ2", W'(f_occ), W'(1));
    s_valid_i = 1'b0; f_valid_i = 1'b0;
    tick();
    check("str_s_drain_v", W'(s_valid_o), W'(0)); check("str_s_drain_occ", W'(s_occ), W'(0));
    check("str_f_drain_v", W'(f_valid_o), W'(0)); check("str_f_drain_occ", W'(f_occ), W'(0));

    // ---------------- skid backpressure ----------------
    s_ready_i = 1'b0;
    s_valid_i = 1'b1; s_data_i = 32'hA;
    tick();
    check("bp_occ1", W'(s_occ), W'(1)); check("bp_ready1", W'(s_ready_o), W'(1));
    s_data_i = 32'hB;
    tick();
    s_data_i = 32'hC;
    tick();
    check("bp_occ2", W'(s_occ), W'(2));
    check("bp_ready0", W'(s_ready_o), W'(0));
    check("bp_data_a", s_data_o, 32'hA);
    tick();
    check("bp_data_a_stable", s_data_o, 32'hA);
    check("bp_valid_stable", W'(s_valid_o), W'(1));
    s_ready_i = 1'b1;            // 0xA leaves at the next edge
    tick();
    check("bp_out_b", s_data_o, 32'hB); check("bp_occ_after_a", W'(s_occ), W'(1));
    check("bp_ready_after_a", W'(s_ready_o), W'(1));
    tick();                      // 0xB leaves, 0xC captured
    check("bp_out_c", s_data_o, 32'hC); check("bp_valid_c", W'(s_valid_o), W'(1));
    s_valid_i = 1'b0;
    tick();                      // 0xC leaves
    check("bp_empty_occ", W'(s_occ), W'(0)); check("bp_empty_valid", W'(s_valid_o), W'(0));

    // ---------------- flush in FULL with a same-edge input ----------------
    s_ready_i = 1'b0;
    s_valid_i = 1'b1; s_data_i = 32'h1;
    tick();
    s_data_i = 32'h2;
    tick();
    check("fl_full", W'(s_occ), W'(2));
    s_flush = 1'b1; s_data_i = 32'h55;
    tick();
    check("fl_valid", W'(s_valid_o), W'(0));
    check("fl_occ",   W'(s_occ), W'(0));
    check("fl_ready", W'(s_ready_o), W'(1));
    s_flush = 1'b0; s_valid_i = 1'b0; s_ready_i = 1'b1;
    tick();
    check("fl_post_valid1", W'(s_valid_o), W'(0));
    tick();
    check("fl_post_valid2", W'(s_valid_o), W'(0));
    check("fl_post_occ2",   W'(s_occ), W'(0));

    // ---------------- single-register stall ----------------
    f_ready_i = 1'b1; f_valid_i = 1'b1; f_data_i = 32'h66;
    tick();
    check("st_load", f_data_o, 32'h66);
    f_ready_i = 1'b0; f_data_i = 32'h99;
    #1;
    check("st_ready0", W'(f_ready_o), W'(0));
    tick();
    check("st_hold_data",  f_data_o, 32'h66);
    check("st_hold_valid", W'(f_valid_o), W'(1));
    f_ready_i = 1'b1; f_data_i = 32'h77;
    #1;
    check("st_ready_comb", W'(f_ready_o), W'(1));
    tick();
    check("st_data77", f_data_o, 32'h77);
    check("st_occ1",   W'(f_occ), W'(1));
    f_flush = 1'b1; f_data_i = 32'h88;
    tick();
    check("st_flush_valid", W'(f_valid_o), W'(0));
    check("st_flush_occ",   W'(f_occ), W'(0));
    f_flush = 1'b0; f_valid_i = 1'b0;

    // ---------------- reset mid-stream from FULL ----------------
    s_ready_i = 1'b0; s_valid_i = 1'b1; s_data_i = 32'h3;
    tick();
    s_data_i = 32'h4;
    tick();
    check("mr_full", W'(s_occ), W'(2));
    s_ready_i = 1'b1; rst = 1'b1;
    tick();
    check("mr_valid", W'(s_valid_o), W'(0));
    check("mr_occ",   W'(s_occ), W'(0));
    check("mr_data",  s_data_o, 32'h0);
    check("mr_f_data", f_data_o, F_RST);
    rst = 1'b0; s_valid_i = 1'b0;
    tick();
    check("mr_post_valid", W'(s_valid_o), W'(0));
    check("mr_post_occ",   W'(s_occ), W'(0));
    check("mr_post_ready", W'(s_ready_o), W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline-stage register. It is the next generation of the plain IF/ID, ID/EX, EX/MEM and MEM/WB latches in the 5-stage pipelined CPU. It adds a valid/ready handshake, per-stage stall (backpressure), synchronous flush for branch/hazard squash, and an optional 2-entry skid buffer that breaks the combinational ready path. One instance sits between each pair of adjacent pipeline stages.

Parameters:
- WIDTH, 32: payload width in bits (the bundled control and data fields of the stage).
- SKID, 1: buffer mode. 0 = single register with combinational ready. 1 = two-entry skid buffer with registered ready.
- RESET_VAL, 0 (WIDTH bits): value loaded into data_o on reset.

Ports:
- clk_i, input, 1: clock; all state updates on rising edge.
- rst_i, input, 1: reset; synchronous, active-high.
- valid_i, input, 1: upstream stage presents a valid payload.
- ready_o, output, 1: this stage can accept a payload.
- data_i, input, WIDTH: upstream payload.
- flush_i, input, 1: squash all held entries (branch taken or hazard kill).
- valid_o, output, 1: payload on data_o is valid.
- ready_i, input, 1: downstream stage accepts a payload (0 = stall).
- data_o, output, WIDTH: payload to the downstream stage.
- occupancy_o, output, 2: number of entries held (0..2; never exceeds 1 when SKID=0).

Behaviour:
- Handshake definitions:
  - Input transfer: valid_i && ready_o at a rising edge.
  - Output transfer: valid_o && ready_i at a rising edge.
- Latency 1 cycle from data_i to data_o. Sustained throughput is 1 payload per cycle.
- Ordering and stability:
  - Payloads leave in arrival order; none is dropped or duplicated except by flush.
  - data_o and valid_o hold stable while valid_o=1 and ready_i=0.
- Priority per edge: rst_i > flush_i > normal operation.
- Reset (rst_i=1 at an edge, also mid-operation in any state):
  - valid_o=0, data_o=RESET_VAL, occupancy_o=0.
  - Skid entry invalidated; ready_o=1 in the following cycle.
  - Inputs are ignored during that edge.
- Flush (flush_i=1, rst_i=0):
  - Next cycle: valid_o=0, occupancy_o=0; skid entry invalidated.
  - data_o value is don't-care (implementation may keep it).
  - An input transfer in the same edge is discarded.
  - An output transfer in the same edge is counted as delivered.
- SKID=0:
  - ready_o = !valid_o || ready_i (combinational).
  - When ready_o=1: valid_o<=valid_i; data_o<=data_i only if valid_i=1.
  - occupancy_o = {1'b0, valid_o}.
- SKID=1 state machine (state equals occupancy_o):
  - ready_o = (state != FULL); it is a registered signal.
  - EMPTY: on input transfer, main<=data_i, go to ONE.
  - ONE, input and output transfer: main<=data_i, stay in ONE.
  - ONE, input transfer only: skid<=data_i, go to FULL.
  - ONE, output transfer only: go to EMPTY.
  - ONE, neither: hold.
  - FULL: no input is accepted. On output transfer, main<=skid, go to ONE; otherwise hold.
  - data_o always reflects the main entry; valid_o = (state != EMPTY).
- No combinational path from ready_i to ready_o when SKID=1.
- No X propagation: held data after reset is always RESET_VAL or a captured data_i.

Test Plan:
- Reset: rst_i=1 for 2 cycles with valid_i=1, data_i=0xDEAD. Required: valid_o=0, data_o=0, occupancy_o=0; ready_o=1 after release.
- Streaming (both SKID modes): ready_i=1; push 0x11, 0x22, 0x33 on consecutive cycles. Required: data_o shows 0x11, 0x22, 0x33 on the next three cycles with valid_o=1 and no bubbles.
- Backpressure (SKID=1): ready_i=0; push 0xA then 0xB; hold 0xC on input. Required: occupancy_o=2, ready_o=0, data_o=0xA stable. Then ready_i=1: outputs 0xA, 0xB, 0xC in order and occupancy_o returns to 0.
- Flush in FULL with simultaneous valid_i=1, data_i=0x55. Required next cycle: valid_o=0, occupancy_o=0, ready_o=1. Neither 0x55 nor the held entries ever appear with valid_o=1.
- SKID=0 stall: valid_o=1, ready_i=0. Required: ready_o=0 and data_o held. Raise ready_i with valid_i=1, data_i=0x77 in the same cycle. Required: ready_o=1 immediately and data_o=0x77 next cycle.
- Reset mid-stream: assert rst_i while in FULL with ready_i=1. Required next cycle: valid_o=0, occupancy_o=0, data_o=RESET_VAL, and no output transfer afterward.
